// File: rtl/feature_epoch_scheduler.sv
// Feature epoch scheduler: streams samples into a feature engine,
// waits for the engine result and serializes the feature words.
//
// Ports:
//   clk, rst        clock, synchronous active-low reset
//   en              run enable
//   s_data/s_valid  input sample stream, s_ready accept
//   fe_*            feature engine control, sample and result bus
//   out_*           serialized feature word stream
//   epoch_done      one-cycle pulse when an epoch's words are sent
//   epoch_cnt       completed epochs (wraps)
//   drop_cnt        rejected samples (saturates)
//   err_timeout     sticky engine timeout flag
module feature_epoch_scheduler #(
    parameter int EPOCH_LENGTH   = 256,
    parameter int NUM_FEATURES   = 27,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic [31:0]                s_data,
    input  logic                       s_valid,
    output logic                       s_ready,
    output logic                       fe_en,
    output logic                       fe_clear,
    output logic [31:0]                fe_data,
    output logic                       fe_in_valid,
    output logic                       fe_new_sample_flag,
    input  logic                       fe_valid,
    input  logic [NUM_FEATURES*32-1:0] fe_features,
    output logic [31:0]                out_data,
    output logic [4:0]                 out_index,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       out_last,
    output logic                       epoch_done,
    output logic [15:0]                epoch_cnt,
    output logic [15:0]                drop_cnt,
    output logic                       err_timeout
);

    localparam int CW = $clog2(EPOCH_LENGTH + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int FW = NUM_FEATURES * 32;

    localparam logic [CW-1:0] CNT_LAST = CW'(EPOCH_LENGTH - 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [4:0]    IDX_LAST = 5'(NUM_FEATURES - 1);

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        WAIT_FEAT,
        DRAIN
    } state_t;

    state_t        state;
    logic [CW-1:0] smp_cnt;
    logic [TW-1:0] tmo_cnt;
    logic [FW-1:0] feat;
    logic          accept;
    logic [4:0]    idx_nxt;

    assign accept  = s_valid & s_ready;
    assign idx_nxt = out_index + 5'd1;

    // The sample strobe and the new-sample flag are the same register.
    assign fe_new_sample_flag = fe_in_valid;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= IDLE;
            smp_cnt     <= '0;
            tmo_cnt     <= '0;
            feat        <= '0;
            s_ready     <= 1'b0;
            fe_en       <= 1'b0;
            fe_clear    <= 1'b0;
            fe_data     <= '0;
            fe_in_valid <= 1'b0;
            out_data    <= '0;
            out_index   <= '0;
            out_valid   <= 1'b0;
            out_last    <= 1'b0;
            epoch_done  <= 1'b0;
            epoch_cnt   <= '0;
            drop_cnt    <= '0;
            err_timeout <= 1'b0;
        end else begin
            fe_clear    <= 1'b0;
            epoch_done  <= 1'b0;
            fe_in_valid <= 1'b0;

            if (s_valid && !s_ready && drop_cnt != 16'hFFFF)
                drop_cnt <= drop_cnt + 16'd1;

            // Accepted samples are forwarded even in an aborting cycle.
            if (accept) begin
                fe_data     <= s_data;
                fe_in_valid <= 1'b1;
            end

            unique case (state)
                IDLE: begin
                    if (en) begin
                        fe_clear <= 1'b1;
                        smp_cnt  <= '0;
                        s_ready  <= 1'b1;
                        fe_en    <= 1'b1;
                        state    <= STREAM;
                    end
                end
                STREAM: begin
                    if (!en) begin
                        smp_cnt <= '0;
                        s_ready <= 1'b0;
                        fe_en   <= 1'b0;
                        state   <= IDLE;
                    end else if (accept) begin
                        if (smp_cnt == CNT_LAST) begin
                            smp_cnt <= '0;
                            tmo_cnt <= '0;
                            s_ready <= 1'b0;
                            state   <= WAIT_FEAT;
                        end else begin
                            smp_cnt <= smp_cnt + 1'b1;
                        end
                    end
                end
                WAIT_FEAT: begin
                    // A result arriving on the timeout cycle still wins.
                    if (fe_valid) begin
                        feat      <= fe_features;
                        out_index <= '0;
                        out_data  <= fe_features[31:0];
                        out_valid <= 1'b1;
                        out_last  <= (IDX_LAST == 5'd0);
                        state     <= DRAIN;
                    end else if (tmo_cnt == TMO_LAST) begin
                        err_timeout <= 1'b1;
                        fe_clear    <= 1'b1;
                        s_ready     <= en;
                        fe_en       <= en;
                        state       <= en ? STREAM : IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                DRAIN: begin
                    if (out_ready) begin
                        if (out_last) begin
                            out_valid  <= 1'b0;
                            out_last   <= 1'b0;
                            epoch_done <= 1'b1;
                            epoch_cnt  <= epoch_cnt + 16'd1;
                            // Next epoch starts with a clean engine.
                            fe_clear   <= en;
                            s_ready    <= en;
                            fe_en      <= en;
                            state      <= en ? STREAM : IDLE;
                        end else begin
                            out_index <= idx_nxt;
                            out_data  <= feat[{idx_nxt, 5'b0} +: 32];
                            out_last  <= (idx_nxt == IDX_LAST);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_feature_epoch_scheduler.sv
// Self-checking bench for feature_epoch_scheduler: directed epochs,
// table-driven drain checks, drops, timeout, abort and reset.
module tb_feature_epoch_scheduler;

    localparam int NF = 27;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic [31:0]   s_data;
    logic          s_valid;
    logic          s_ready;
    logic          fe_en;
    logic          fe_clear;
    logic [31:0]   fe_data;
    logic          fe_in_valid;
    logic          fe_new_sample_flag;
    logic          fe_valid;
    logic [NF*32-1:0] fe_features;
    logic [31:0]   out_data;
    logic [4:0]    out_index;
    logic          out_valid;
    logic          out_ready;
    logic          out_last;
    logic          epoch_done;
    logic [15:0]   epoch_cnt;
    logic [15:0]   drop_cnt;
    logic          err_timeout;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        logic       rdy;
        logic [4:0] idx;
        logic       last;
    } vec_t;

    vec_t tbl_a [64];
    vec_t tbl_b [64];
    int   nrow_a;
    int   nrow_b;

    feature_epoch_scheduler dut (
        .clk                (clk),
        .rst                (rst),
        .en                 (en),
        .s_data             (s_data),
        .s_valid            (s_valid),
        .s_ready            (s_ready),
        .fe_en              (fe_en),
        .fe_clear           (fe_clear),
        .fe_data            (fe_data),
        .fe_in_valid        (fe_in_valid),
        .fe_new_sample_flag (fe_new_sample_flag),
        .fe_valid           (fe_valid),
        .fe_features        (fe_features),
        .out_data           (out_data),
        .out_index          (out_index),
        .out_valid          (out_valid),
        .out_ready          (out_ready),
        .out_last           (out_last),
        .epoch_done         (epoch_done),
        .epoch_cnt          (epoch_cnt),
        .drop_cnt           (drop_cnt),
        .err_timeout        (err_timeout)
    );

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: got no finish, required finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic run_samples(input int n, input int base);
        int bad = 0;
        for (int i = 0; i < n; i++) begin
            s_data  = 32'(base + i);
            s_valid = 1'b1;
            tick();
            if (!(fe_in_valid && fe_new_sample_flag &&
                  fe_data == 32'(base + i)))
                bad++;
        end
        chk("fe_mirror", 32'(bad), 32'd0);
    endtask

    task automatic wait_feat(input int base);
        for (int k = 0; k < NF; k++)
            fe_features[32*k +: 32] = 32'(base + k);
        for (int i = 0; i < 9; i++)
            tick();
        fe_valid = 1'b1;
        tick();
        fe_valid = 1'b0;
    endtask

    task automatic drain(input int t, input int base);
        vec_t v;
        int   n;
        n = (t == 0) ? nrow_a : nrow_b;
        for (int r = 0; r < n; r++) begin
            v = (t == 0) ? tbl_a[r] : tbl_b[r];
            out_ready = v.rdy;
            chk("out_valid", out_valid, 1'b1);
            chk("out_index", out_index, v.idx);
            chk("out_data", out_data, 32'(base) + v.idx);
            chk("out_last", out_last, v.last);
            tick();
        end
        chk("epoch_done", epoch_done, 1'b1);
        chk("done_valid", out_valid, 1'b0);
    endtask

    initial begin
        int n;
        int idx;
        int r;
        logic rdy;
        logic seen;

        // Drain tables: all-ready, and a 1-0-1-1-0 stall pattern.
        for (int t = 0; t < 2; t++) begin
            idx = 0;
            r   = 0;
            while (idx < NF) begin
                rdy = (t == 0) ? 1'b1 : ((r % 3) != 1);
                if (t == 0) begin
                    tbl_a[r].rdy  = rdy;
                    tbl_a[r].idx  = 5'(idx);
                    tbl_a[r].last = (idx == NF - 1);
                end else begin
                    tbl_b[r].rdy  = rdy;
                    tbl_b[r].idx  = 5'(idx);
                    tbl_b[r].last = (idx == NF - 1);
                end
                if (rdy) idx++;
                r++;
            end
            if (t == 0) nrow_a = r;
            else        nrow_b = r;
        end

        rst         = 1'b0;
        en          = 1'b0;
        s_data      = '0;
        s_valid     = 1'b0;
        fe_valid    = 1'b0;
        fe_features = '0;
        out_ready   = 1'b0;
        for (int i = 0; i < 3; i++)
            tick();
        chk("rst_s_ready", s_ready, 1'b0);
        chk("rst_fe_en", fe_en, 1'b0);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_epoch_cnt", epoch_cnt, 16'd0);
        chk("rst_drop_cnt", drop_cnt, 16'd0);
        chk("rst_err", err_timeout, 1'b0);
        chk("rst_fe_data", fe_data, 32'd0);
        chk("rst_out_data", out_data, 32'd0);

        rst = 1'b1;
        en  = 1'b1;
        tick();
        chk("start_clear", fe_clear, 1'b1);
        chk("start_ready", s_ready, 1'b1);
        chk("start_fe_en", fe_en, 1'b1);

        // Epoch 1: basic flow.
        run_samples(256, 0);
        s_valid = 1'b0;
        chk("wait_ready", s_ready, 1'b0);
        chk("wait_fe_en", fe_en, 1'b1);
        out_ready = 1'b1;
        wait_feat(100);
        drain(0, 100);
        chk("epoch_cnt1", epoch_cnt, 16'd1);
        tick();
        chk("done_pulse", epoch_done, 1'b0);

        // Epoch 2: s_valid held through WAIT_FEAT and DRAIN.
        run_samples(256, 1000);
        s_data = 32'hdead;
        wait_feat(150);
        drain(0, 150);
        chk("drop_cnt", drop_cnt, 16'd37);
        chk("epoch_cnt2", epoch_cnt, 16'd2);

        // Epoch 3: en low in WAIT_FEAT, stalls in DRAIN.
        run_samples(256, 2000);
        s_valid = 1'b0;
        en      = 1'b0;
        wait_feat(200);
        en = 1'b1;
        drain(1, 200);
        chk("epoch_cnt3", epoch_cnt, 16'd3);
        chk("drop_hold", drop_cnt, 16'd37);

        // Epoch 4: engine never answers.
        run_samples(256, 3000);
        s_valid = 1'b0;
        n = 0;
        do begin
            tick();
            n++;
        end while (!err_timeout && n < 5000);
        chk("tmo_cycles", 32'(n), 32'd4096);
        chk("tmo_err", err_timeout, 1'b1);
        chk("tmo_clear", fe_clear, 1'b1);
        chk("tmo_ready", s_ready, 1'b1);
        chk("tmo_epoch", epoch_cnt, 16'd3);

        fe_valid = 1'b1;
        tick();
        fe_valid = 1'b0;
        chk("stray_valid", out_valid, 1'b0);

        // Abort after 100 samples, abort-cycle sample still forwarded.
        run_samples(100, 4000);
        en      = 1'b0;
        s_data  = 32'd4100;
        s_valid = 1'b1;
        tick();
        s_valid = 1'b0;
        chk("abort_fwd", fe_in_valid, 1'b1);
        chk("abort_data", fe_data, 32'd4100);
        chk("abort_ready", s_ready, 1'b0);
        chk("abort_fe_en", fe_en, 1'b0);
        tick();
        en = 1'b1;
        tick();
        chk("reen_clear", fe_clear, 1'b1);
        chk("reen_ready", s_ready, 1'b1);
        run_samples(255, 5000);
        chk("full_255", s_ready, 1'b1);
        run_samples(1, 5255);
        s_valid = 1'b0;
        chk("full_256", s_ready, 1'b0);

        // Reset in the middle of DRAIN.
        wait_feat(300);
        out_ready = 1'b0;
        tick();
        tick();
        chk("pre_rst_valid", out_valid, 1'b1);
        rst = 1'b0;
        tick();
        chk("mrst_valid", out_valid, 1'b0);
        chk("mrst_data", out_data, 32'd0);
        chk("mrst_fe_data", fe_data, 32'd0);
        chk("mrst_index", out_index, 5'd0);
        chk("mrst_epoch", epoch_cnt, 16'd0);
        chk("mrst_drop", drop_cnt, 16'd0);
        chk("mrst_err", err_timeout, 1'b0);
        chk("mrst_ready", s_ready, 1'b0);
        chk("mrst_fe_en", fe_en, 1'b0);
        chk("mrst_done", epoch_done, 1'b0);
        rst       = 1'b1;
        en        = 1'b0;
        out_ready = 1'b1;
        seen      = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            seen = seen | epoch_done | out_valid;
        end
        chk("post_rst_quiet", seen, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/feature_epoch_scheduler.md
FEATURE_EPOCH_SCHEDULER -- requirements
Module: feature_epoch_scheduler

Interface
REQ-001 SHALL have parameter EPOCH_LENGTH, default 256, meaning samples per epoch.
REQ-002 SHALL have parameter NUM_FEATURES, default 27, meaning number of 32-bit feature words per epoch.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 4096, meaning the maximum wait for engine valid after the last sample.
REQ-004 SHALL have one clock and a synchronous, active-low reset: clk  in  1  rising-edge clock.
REQ-005 SHALL have rst  in  1  synchronous active-low reset; 0 = reset.
REQ-006 SHALL have en  in  1  run enable.
REQ-007 SHALL have s_data  in  32  signed input sample.
REQ-008 SHALL have s_valid  in  1  input sample valid.
REQ-009 SHALL have s_ready  out  1  scheduler accepts sample.
REQ-010 SHALL have fe_en  out  1  engine enable.
REQ-011 SHALL have fe_clear  out  1  one-cycle engine accumulator clear, active-high.
REQ-012 SHALL have fe_data  out  32  sample to engine.
REQ-013 SHALL have fe_in_valid  out  1  sample strobe to engine.
REQ-014 SHALL have fe_new_sample_flag  out  1  identical to fe_in_valid.
REQ-015 SHALL have fe_valid  in  1  engine features-ready pulse.
REQ-016 SHALL have fe_features  in  NUM_FEATURES*32  flattened feature bus; word k is in bits [32k+31:32k]; zero_counter is zero-extended to 32 bits.
REQ-017 SHALL have out_data  out  32  serialized feature word.
REQ-018 SHALL have out_index  out  5  index of the current word.
REQ-019 SHALL have out_valid  out  1  word valid.
REQ-020 SHALL have out_ready  in  1  downstream ready.
REQ-021 SHALL have out_last  out  1  high with the word at index NUM_FEATURES-1.
REQ-022 SHALL have epoch_done  out  1  one-cycle pulse after the last word transfers.
REQ-023 SHALL have epoch_cnt  out  16  completed epochs, wraps modulo 2^16.
REQ-024 SHALL have drop_cnt  out  16  samples rejected, saturates at 0xFFFF.
REQ-025 SHALL have err_timeout  out  1  sticky engine-timeout flag.

Function
REQ-026 SHALL implement states IDLE, STREAM, WAIT_FEAT and DRAIN.
REQ-027 IDLE SHALL behave as follows: s_ready=0 and fe_en=0; when en=1, pulse fe_clear for 1 cycle, clear the sample counter, and move to STREAM.
REQ-028 STREAM SHALL assert s_ready=1 and fe_en=1.
REQ-029 In STREAM, every accepted sample (s_valid&s_ready) SHALL appear on fe_data with fe_in_valid=fe_new_sample_flag=1 exactly 1 cycle later, with no gaps and no reordering.
REQ-030 In STREAM, the sample counter SHALL increment per accepted sample; on acceptance of sample EPOCH_LENGTH it SHALL reset to 0 and the state SHALL move to WAIT_FEAT.
REQ-031 In STREAM, en=0 SHALL abort the epoch: clear the sample counter and move to IDLE; a sample accepted in that same cycle is still forwarded.
REQ-032 WAIT_FEAT SHALL hold s_ready=0 with fe_en=1, and the timeout counter SHALL count cycles from entry.
REQ-033 In WAIT_FEAT, fe_valid=1 SHALL register the whole fe_features bus, reset word index to 0, and move to DRAIN.
REQ-034 In WAIT_FEAT, reaching TIMEOUT_CYCLES without fe_valid SHALL set err_timeout, pulse fe_clear, leave epoch_cnt unchanged, and move to STREAM (or to IDLE if en=0).
REQ-035 If fe_valid and the timeout occur in the same cycle, fe_valid SHALL take priority.
REQ-036 fe_valid outside WAIT_FEAT SHALL be ignored.
REQ-037 DRAIN SHALL drive out_valid=1, out_data = registered word[index], and out_index = index; s_ready SHALL be 0.
REQ-038 In DRAIN, the index SHALL advance only on out_valid&out_ready; out_data and out_index SHALL stay stable while out_ready=0.
REQ-039 In DRAIN, the transfer of word NUM_FEATURES-1 (out_last=1) SHALL cause the next cycle to have epoch_done=1, out_valid=0 and epoch_cnt incremented, with state STREAM if en=1 else IDLE.
REQ-040 en=0 during WAIT_FEAT or DRAIN SHALL NOT abort the epoch; the epoch SHALL complete first.
REQ-041 drop_cnt SHALL increment in every cycle with s_valid=1 and s_ready=0 (any state), saturating at 0xFFFF.
REQ-042 All outputs SHALL be registered.

Reset
REQ-043 When rst=0 at a clock edge, the state SHALL become IDLE; all counters, err_timeout and the index SHALL be 0; the output strobes, out_valid, fe_en, fe_clear and s_ready SHALL be 0; fe_data and out_data SHALL be 0.
REQ-044 Reset asserted in any state SHALL discard the partial epoch and the captured features; no epoch_done pulse is generated.

Verification
REQ-045 Basic epoch: en=1, 256 consecutive samples 0..255, fe_valid 10 cycles later with word k=k+100, out_ready=1 -> fe_data mirrors samples with 1-cycle lag; 27 words 100..126 with indices 0..26; out_last on index 26; epoch_done pulses; epoch_cnt=1.
REQ-046 Backpressure: out_ready toggles 1-0-1 -> no word repeated or skipped; out_data is stable while stalled.
REQ-047 Drops: s_valid held high through WAIT_FEAT (10 cycles) and DRAIN (27 cycles) -> drop_cnt=37; next epoch starts at the next sample.
REQ-048 Timeout: no fe_valid after 256 samples -> err_timeout=1 after 4096 cycles; fe_clear pulses; epoch_cnt stays 0; STREAM resumes.
REQ-049 Abort/reset: en=0 after 100 samples -> IDLE; re-enable gives a fe_clear pulse and a full 256-sample epoch. rst=0 mid-DRAIN -> all outputs 0 and no epoch_done.
